riscv_mmio_uart_tx: RTL

- Memory-mapped UART transmitter that sits directly downstream of riscv_top's data-memory bus and snoops the o_riscv_dmem_* outputs.
- Core stores to the TXDATA address are captured into a byte FIFO and serialized 8N1, LSB first, on o_uart_tx.
- Gives bench and FPGA builds a console for program output without modifying the core.
- Write-only from the core's view; status is exported as a word for a future read mux.

---
 rtl/riscv_mmio_uart_tx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/riscv_mmio_uart_tx.sv
// Memory-mapped UART transmitter that snoops core stores to TXDATA/CTRL and
// serializes queued bytes 8N1, LSB first, on o_uart_tx.
module riscv_mmio_uart_tx #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  BASE_ADDR    = XLEN'(32'h0000_1000),
  parameter int unsigned      CLKS_PER_BIT = 868,
  parameter int unsigned      FIFO_DEPTH   = 16,
  parameter int unsigned      FIFO_AW      = 4
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [XLEN-1:0]     i_dmem_addr,
  input  logic                i_dmem_wr_en,
  input  logic [XLEN-1:0]     i_dmem_wr_data,
  input  logic [XLEN/8-1:0]   i_dmem_byte_sel,
  output logic                o_uart_tx,
  output logic                o_tx_busy,
  output logic                o_fifo_full,
  output logic                o_fifo_empty,
  output logic [15:0]         o_drop_cnt,
  output logic [XLEN-1:0]     o_status
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PTR_W  = FIFO_AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic               full_q, full_d, empty_q, empty_d;
  logic               enable_q, enable_d;
  logic [15:0]        drop_q, drop_d;
  logic               pop, push, drop;
  logic [PTR_W-1:0]   fill;
  logic [7:0]         mem [FIFO_DEPTH];

  // Bus decode: only byte lane 0 of the two word registers is observed
  logic addr_hit, hit_tx, hit_ctrl, baud_last;
  assign addr_hit  = i_dmem_wr_en && (i_dmem_addr[XLEN-1:3] == BASE_ADDR[XLEN-1:3])
                     && i_dmem_byte_sel[0];
  assign hit_tx    = addr_hit && (i_dmem_addr[2:0] == 3'd0);
  assign hit_ctrl  = addr_hit && (i_dmem_addr[2:0] == 3'd4);
  assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  logic unused_bits;
  assign unused_bits = ^{i_dmem_wr_data[XLEN-1:8], i_dmem_byte_sel[XLEN/8-1:1]};

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      enable_q <= 1'b1;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      enable_q <= enable_d;
      drop_q   <= drop_d;
    end
  end

  // FIFO storage carries no reset; pointers define validity
  always_ff @(posedge i_clk) begin
    if (push) mem[wptr_q[FIFO_AW-1:0]] <= i_dmem_wr_data[7:0];
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    enable_d = enable_q;
    drop_d   = drop_q;

    case (state_q)
      S_IDLE: begin
        if (enable_q && !empty_q) begin
          pop     = 1'b1;
          shift_d = mem[rptr_q[FIFO_AW-1:0]];
          state_d = S_START;
          baud_d  = '0;
        end
      end
      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          state_d = S_IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the next state so tx changes on the same edge
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);

    // A pop in the same cycle frees a slot for a store into a full FIFO
    push    = hit_tx && (!full_q || pop);
    drop    = hit_tx && full_q && !pop;
    wptr_d  = wptr_q + PTR_W'(push);
    rptr_d  = rptr_q + PTR_W'(pop);
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[FIFO_AW] != rptr_d[FIFO_AW]) &&
              (wptr_d[FIFO_AW-1:0] == rptr_d[FIFO_AW-1:0]);

    if (hit_ctrl) enable_d = i_dmem_wr_data[0];
    if (hit_ctrl && i_dmem_wr_data[1]) drop_d = '0;
    else if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  assign fill         = wptr_q - rptr_q;
  assign o_uart_tx    = tx_q;
  assign o_tx_busy    = busy_q;
  assign o_fifo_full  = full_q;
  assign o_fifo_empty = empty_q;
  assign o_drop_cnt   = drop_q;
  assign o_status     = XLEN'({drop_q, 8'(fill), 5'b0, enable_q, busy_q, full_q});

endmodule
